// File: rtl/matrix_mac_unit.sv
// Signed multiply-accumulate for the matrix engine: ACC += (A - B) * C through a
// 16-cycle shift-add multiplier, with a Q15-scaled readout of ACC onto MDB_OUT.
module matrix_mac_unit (
  input  logic        clk_12,
  input  logic        reset,
  input  logic        LDA,
  input  logic        LDB,
  input  logic        LDC,
  input  logic        CLEARACC,
  input  logic        LAC,
  input  logic [15:0] MDB_RAM,
  output logic        MACFLAG,
  output logic [15:0] MDB_OUT,
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PREP  = 2'd1;
  localparam logic [1:0] ST_MULT  = 2'd2;
  localparam logic [1:0] ST_ACCUM = 2'd3;

  logic [1:0]  state_q;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [15:0] c_q;
  logic [31:0] acc_q;
  logic [3:0]  cnt_q;
  logic        clr_pend_q;
  logic        sign_q;
  logic [31:0] mcand_q;
  logic [15:0] mplier_q;
  logic [31:0] prod_q;

  logic [15:0] a_eff;
  logic [15:0] b_eff;
  logic [15:0] c_eff;
  logic [15:0] diff;
  logic [15:0] abs_d;
  logic [15:0] abs_c;
  logic [31:0] prod_sum;
  logic [31:0] signed_p;

  // PREP sees operands as they will be after any load on the same edge.
  always_comb begin
    a_eff    = LDA ? MDB_RAM : a_q;
    b_eff    = LDB ? MDB_RAM : b_q;
    c_eff    = LDC ? MDB_RAM : c_q;
    diff     = a_eff - b_eff;
    abs_d    = diff[15] ? (~diff + 16'd1) : diff;
    abs_c    = c_eff[15] ? (~c_eff + 16'd1) : c_eff;
    prod_sum = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
    signed_p = sign_q ? (~prod_q + 32'd1) : prod_q;
  end

  assign state_dbg = state_q;

  always_ff @(posedge clk_12) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      a_q        <= 16'd0;
      b_q        <= 16'd0;
      c_q        <= 16'd0;
      acc_q      <= 32'd0;
      cnt_q      <= 4'd0;
      clr_pend_q <= 1'b0;
      sign_q     <= 1'b0;
      mcand_q    <= 32'd0;
      mplier_q   <= 16'd0;
      prod_q     <= 32'd0;
      MACFLAG    <= 1'b1;
      MDB_OUT    <= 16'd0;
    end else begin
      // MACFLAG trails the state by one edge, so it reads low for 18 cycles.
      MACFLAG <= (state_q == ST_IDLE);
      a_q     <= a_eff;
      b_q     <= b_eff;
      c_q     <= c_eff;
      if (LAC) begin
        MDB_OUT <= acc_q[30:15];
      end

      case (state_q)
        ST_IDLE: begin
          if (CLEARACC) begin
            acc_q <= 32'd0;
          end
          if (LDC) begin
            state_q <= ST_PREP;
          end
        end

        ST_PREP: begin
          mcand_q  <= {16'd0, abs_d};
          mplier_q <= abs_c;
          prod_q   <= 32'd0;
          sign_q   <= diff[15] ^ c_eff[15];
          cnt_q    <= 4'd0;
          state_q  <= ST_MULT;
          if (CLEARACC) begin
            clr_pend_q <= 1'b1;
          end
        end

        ST_MULT: begin
          prod_q   <= prod_sum;
          mcand_q  <= {mcand_q[30:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[15:1]};
          cnt_q    <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_q <= ST_ACCUM;
          end
          if (CLEARACC) begin
            clr_pend_q <= 1'b1;
          end
        end

        ST_ACCUM: begin
          // A clear requested mid-operation (or on this edge) discards the old sum.
          if (clr_pend_q || CLEARACC) begin
            acc_q <= signed_p;
          end else begin
            acc_q <= acc_q + signed_p;
          end
          clr_pend_q <= 1'b0;
          state_q    <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
